// File: rtl/sd_read_block_pkg.sv
// Shared types and constants for the SPI-mode single-block reader.
package sd_read_block_pkg;

    typedef enum logic [3:0] {
        IDLE,
        PRE,
        CMD,
        R1WAIT,
        TOKEN,
        DATA,
        CRC,
        POST,
        ERR
    } state_t;

    localparam logic [7:0] CMD17_IDX   = 8'h51;
    localparam logic [7:0] DUMMY_CRC   = 8'hFF;
    localparam logic [7:0] START_TOKEN = 8'hFE;

    localparam logic [1:0] ERR_NONE       = 2'd0;
    localparam logic [1:0] ERR_R1         = 2'd1;
    localparam logic [1:0] ERR_R1_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_TOKEN      = 2'd3;

    // hist[8] is the bit just before the 8-bit window: a data-error token
    // only counts when its window starts right after a 1.
    function automatic logic is_err_token(input logic [8:0] hist);
        return hist[8] && (hist[7:4] == 4'h0) && (hist[3:0] != 4'h0);
    endfunction

endpackage

// File: rtl/sd_read_block_spi_byte_rx.sv
// Serial-in byte assembler: shifts MSB first and flags the 8th bit of each byte.
module spi_byte_rx (
    input  logic       clk,
    input  logic       res,
    input  logic       clr,
    input  logic       en,
    input  logic       bit_in,
    output logic [7:0] byte_next,
    output logic       byte_done,
    output logic       mid_byte
);

    logic [6:0] shift_q, shift_d;
    logic [2:0] cnt_q, cnt_d;

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (clr) begin
            shift_d = '0;
            cnt_d   = '0;
        end else if (en) begin
            shift_d = {shift_q[5:0], bit_in};
            cnt_d   = cnt_q + 3'd1;
        end
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

    // The completed byte includes the bit being sampled this cycle.
    assign byte_next = {shift_q, bit_in};
    assign byte_done = en && !clr && (cnt_q == 3'd7);
    assign mid_byte  = (cnt_q != 3'd0);

endmodule

// File: rtl/sd_read_block.sv
// CMD17 single-block read over SPI: command, R1, start token, data bytes, CRC.
module sd_read_block
    import sd_read_block_pkg::*;
#(
    parameter int unsigned BLOCK_BYTES = 512,
    parameter int unsigned NCR_MAX     = 64,
    parameter int unsigned TOKEN_MAX   = 65535
) (
    input  logic        clk,
    input  logic        res,
    input  logic        init_done,
    input  logic        start,
    input  logic [31:0] addr,
    input  logic        MISO_bit,
    output logic        sd_cs,
    output logic        MOSI_bit,
    output logic        busy,
    output logic [7:0]  data_out,
    output logic        data_valid,
    output logic [15:0] crc_out,
    output logic [7:0]  r1_out,
    output logic        done,
    output logic        error,
    output logic [1:0]  err_code,
    output state_t      dbg_state
);

    localparam logic [12:0] LAST_DATA_BIT = 13'(BLOCK_BYTES * 8 - 1);
    localparam logic [15:0] LAST_NCR      = 16'(NCR_MAX - 1);
    localparam logic [15:0] LAST_TOKEN    = 16'(TOKEN_MAX - 1);

    state_t      state_q, state_d;
    logic [15:0] tmo_q, tmo_d;
    logic [12:0] bit_cnt_q, bit_cnt_d;
    logic [47:0] cmd_sh_q, cmd_sh_d;
    logic [7:0]  hist_q, hist_d;
    logic [7:0]  data_out_q, data_out_d;
    logic        data_valid_q, data_valid_d;
    logic [15:0] crc_q, crc_d;
    logic [7:0]  r1_q, r1_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
    logic [1:0]  err_code_q, err_code_d;

    logic        rx_clr, rx_en, rx_done, rx_mid;
    logic [7:0]  rx_byte;
    logic [8:0]  hist_nx;

    spi_byte_rx u_rx (
        .clk       (clk),
        .res       (res),
        .clr       (rx_clr),
        .en        (rx_en),
        .bit_in    (MISO_bit),
        .byte_next (rx_byte),
        .byte_done (rx_done),
        .mid_byte  (rx_mid)
    );

    assign hist_nx = {hist_q, MISO_bit};

    always_comb begin
        state_d      = state_q;
        tmo_d        = tmo_q;
        bit_cnt_d    = bit_cnt_q;
        cmd_sh_d     = cmd_sh_q;
        hist_d       = hist_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        crc_d        = crc_q;
        r1_d         = r1_q;
        done_d       = 1'b0;
        error_d      = error_q;
        err_code_d   = err_code_q;
        rx_clr       = 1'b0;
        rx_en        = 1'b0;
        case (state_q)
            IDLE: begin
                rx_clr = 1'b1;
                // done_q blocks a start arriving in the same cycle as done.
                if (start && init_done && !done_q) begin
                    cmd_sh_d   = {CMD17_IDX, addr, DUMMY_CRC};
                    error_d    = 1'b0;
                    err_code_d = ERR_NONE;
                    crc_d      = '0;
                    tmo_d      = '0;
                    state_d    = PRE;
                end
            end
            PRE: begin
                tmo_d = tmo_q + 16'd1;
                if (tmo_q == 16'd7) begin
                    tmo_d   = '0;
                    state_d = CMD;
                end
            end
            CMD: begin
                cmd_sh_d = {cmd_sh_q[46:0], 1'b1};
                tmo_d    = tmo_q + 16'd1;
                if (tmo_q == 16'd47) begin
                    tmo_d   = '0;
                    state_d = R1WAIT;
                end
            end
            R1WAIT: begin
                rx_en = rx_mid || !MISO_bit;
                if (rx_done) begin
                    r1_d  = rx_byte;
                    tmo_d = '0;
                    if (rx_byte != 8'h00) begin
                        err_code_d = ERR_R1;
                        state_d    = ERR;
                    end else begin
                        hist_d  = '0;
                        state_d = TOKEN;
                    end
                end else if (!rx_mid && MISO_bit && (tmo_q == LAST_NCR)) begin
                    err_code_d = ERR_R1_TIMEOUT;
                    tmo_d      = '0;
                    state_d    = ERR;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end
            TOKEN: begin
                hist_d = hist_nx[7:0];
                tmo_d  = tmo_q + 16'd1;
                if (hist_nx[7:0] == START_TOKEN) begin
                    tmo_d     = '0;
                    bit_cnt_d = '0;
                    state_d   = DATA;
                end else if (is_err_token(hist_nx) || (tmo_q == LAST_TOKEN)) begin
                    err_code_d = ERR_TOKEN;
                    tmo_d      = '0;
                    state_d    = ERR;
                end
            end
            DATA: begin
                rx_en     = 1'b1;
                bit_cnt_d = bit_cnt_q + 13'd1;
                if (rx_done) begin
                    data_out_d   = rx_byte;
                    data_valid_d = 1'b1;
                end
                if (bit_cnt_q == LAST_DATA_BIT) begin
                    bit_cnt_d = '0;
                    state_d   = CRC;
                end
            end
            CRC: begin
                rx_en     = 1'b1;
                bit_cnt_d = bit_cnt_q + 13'd1;
                if (rx_done) begin
                    crc_d = {crc_q[7:0], rx_byte};
                end
                if (bit_cnt_q == 13'd15) begin
                    bit_cnt_d = '0;
                    tmo_d     = '0;
                    state_d   = POST;
                end
            end
            POST, ERR: begin
                tmo_d = tmo_q + 16'd1;
                if (tmo_q == 16'd7) begin
                    tmo_d   = '0;
                    done_d  = 1'b1;
                    error_d = (state_q == ERR);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q      <= IDLE;
            tmo_q        <= '0;
            bit_cnt_q    <= '0;
            cmd_sh_q     <= '1;
            hist_q       <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            crc_q        <= '0;
            r1_q         <= 8'hFF;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            err_code_q   <= ERR_NONE;
        end else begin
            state_q      <= state_d;
            tmo_q        <= tmo_d;
            bit_cnt_q    <= bit_cnt_d;
            cmd_sh_q     <= cmd_sh_d;
            hist_q       <= hist_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            crc_q        <= crc_d;
            r1_q         <= r1_d;
            done_q       <= done_d;
            error_q      <= error_d;
            err_code_q   <= err_code_d;
        end
    end

    // The card is selected only while bits are exchanged with it.
    assign sd_cs      = !(state_q inside {CMD, R1WAIT, TOKEN, DATA, CRC});
    assign MOSI_bit   = (state_q == CMD) ? cmd_sh_q[47] : 1'b1;
    assign busy       = (state_q != IDLE);
    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign crc_out    = crc_q;
    assign r1_out     = r1_q;
    assign done       = done_q;
    assign error      = error_q;
    assign err_code   = err_code_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_sd_read_block.sv
// Directed bench for sd_read_block: table of card behaviours plus reset/ignore sequences.
module tb_sd_read_block;
    import sd_read_block_pkg::*;

    localparam int BYTES = 512;

    typedef struct {
        logic [31:0] addr;
        int          r1_pre;
        logic [7:0]  r1v;
        int          tok_pre;
        logic        tok_en;
        logic [7:0]  tok;
        logic        data_en;
        int          exp_done;
        logic        exp_err;
        logic [1:0]  exp_code;
        logic [7:0]  exp_r1;
        int          exp_valid;
        logic [15:0] exp_crc;
    } vec_t;

    logic        clk = 1'b0;
    logic        res, init_done, start, MISO_bit;
    logic [31:0] addr;
    logic        sd_cs, MOSI_bit, busy, data_valid, done, error;
    logic [7:0]  data_out, r1_out;
    logic [15:0] crc_out;
    logic [1:0]  err_code;
    state_t      dbg_state;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic        miso_q[$];
    logic [7:0]  exp_q[$];
    vec_t        vecs[6];

    always #5 clk = ~clk;

    sd_read_block dut (
        .clk        (clk),
        .res        (res),
        .init_done  (init_done),
        .start      (start),
        .addr       (addr),
        .MISO_bit   (MISO_bit),
        .sd_cs      (sd_cs),
        .MOSI_bit   (MOSI_bit),
        .busy       (busy),
        .data_out   (data_out),
        .data_valid (data_valid),
        .crc_out    (crc_out),
        .r1_out     (r1_out),
        .done       (done),
        .error      (error),
        .err_code   (err_code),
        .dbg_state  (dbg_state)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) miso_q.push_back(b[i]);
    endtask

    // Card stream starts at the accept cycle (k = 0); R1 is sampled from k = 57.
    task automatic run_txn(input vec_t v, input int abort_at, output int done_cyc,
                           output int n_valid, output logic [47:0] frame,
                           output logic busy1, output logic err_at_done,
                           output int first_valid);
        int last_valid;
        logic [7:0] b;
        done_cyc = -1; n_valid = 0; frame = '0; busy1 = 1'b0;
        err_at_done = 1'b0; first_valid = -1; last_valid = -1;
        miso_q.delete();
        exp_q.delete();
        repeat (57 + v.r1_pre) miso_q.push_back(1'b1);
        push_byte(v.r1v);
        if (v.r1v == 8'h00) begin
            repeat (v.tok_pre) miso_q.push_back(1'b1);
            if (v.tok_en) push_byte(v.tok);
            if (v.data_en) begin
                for (int n = 0; n < BYTES; n++) begin
                    b = 8'(n);
                    exp_q.push_back(b);
                    push_byte(b);
                end
                push_byte(8'hA5);
                push_byte(8'hC3);
            end
        end
        for (int k = 0; k < 70000; k++) begin
            @(negedge clk);
            if (k == 1) busy1 = busy;
            if (k == 8) begin
                chk("pre_cs_high", 64'(sd_cs), 64'd1);
                chk("pre_mosi_high", 64'(MOSI_bit), 64'd1);
            end
            if (k == 9) chk("cmd_cs_low", 64'(sd_cs), 64'd0);
            if (k >= 9 && k <= 56) frame = {frame[46:0], MOSI_bit};
            if (data_valid) begin
                if (first_valid < 0) first_valid = k;
                else chk("strobe_gap", 64'(k - last_valid), 64'd8);
                last_valid = k;
                n_valid++;
                if (exp_q.size() == 0) chk("extra_byte", 64'd1, 64'd0);
                else chk("data_byte", 64'(data_out), 64'(exp_q.pop_front()));
                if (n_valid == abort_at) begin
                    res = 1'b1;
                    #1;
                    chk("rst_cs", 64'(sd_cs), 64'd1);
                    chk("rst_busy", 64'(busy), 64'd0);
                    chk("rst_valid", 64'(data_valid), 64'd0);
                    chk("rst_r1", 64'(r1_out), 64'hFF);
                    chk("rst_state", 64'(dbg_state), 64'(IDLE));
                    start = 1'b0;
                    return;
                end
            end
            if (done) begin
                done_cyc = k;
                err_at_done = error;
                start = 1'b1;
                break;
            end
            start     = (k == 0) || (k == 30);
            addr      = (k == 0) ? v.addr : ~v.addr;
            init_done = !(k >= 100 && k < 200);
            MISO_bit  = (miso_q.size() > 0) ? miso_q.pop_front() : 1'b1;
        end
        @(negedge clk);
        start = 1'b0;
        init_done = 1'b1;
        MISO_bit = 1'b1;
        chk("start_at_done_ignored", 64'(busy), 64'd0);
        chk("idle_cs", 64'(sd_cs), 64'd1);
        chk("idle_mosi", 64'(MOSI_bit), 64'd1);
    endtask

    initial begin
        int dc, nv, fv;
        logic [47:0] fr;
        logic b1, ed;

        res = 1'b1; init_done = 1'b1; start = 1'b0; addr = '0; MISO_bit = 1'b1;

        vecs[0] = '{32'h0000_1234, 0, 8'h00, 0, 1'b1, 8'hFE, 1'b1, 4193, 1'b0, 2'd0, 8'h00, 512, 16'hA5C3};
        vecs[1] = '{32'hDEAD_BEEF, 3, 8'h00, 20, 1'b1, 8'hFE, 1'b1, 4216, 1'b0, 2'd0, 8'h00, 512, 16'hA5C3};
        vecs[2] = '{32'h0000_0007, 5, 8'h04, 0, 1'b0, 8'h00, 1'b0, 78, 1'b1, 2'd1, 8'h04, 0, 16'h0000};
        vecs[3] = '{32'h8000_0001, 100, 8'hFF, 0, 1'b0, 8'h00, 1'b0, 129, 1'b1, 2'd2, 8'h04, 0, 16'h0000};
        vecs[4] = '{32'h0000_00AA, 0, 8'h00, 3, 1'b1, 8'h08, 1'b0, 84, 1'b1, 2'd3, 8'h00, 0, 16'h0000};
        vecs[5] = '{32'h1234_5678, 0, 8'h00, 0, 1'b0, 8'h00, 1'b0, 65608, 1'b1, 2'd3, 8'h00, 0, 16'h0000};

        repeat (3) @(negedge clk);
        chk("reset_cs", 64'(sd_cs), 64'd1);
        chk("reset_mosi", 64'(MOSI_bit), 64'd1);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_valid", 64'(data_valid), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_error", 64'(error), 64'd0);
        chk("reset_data", 64'(data_out), 64'd0);
        chk("reset_crc", 64'(crc_out), 64'd0);
        chk("reset_r1", 64'(r1_out), 64'hFF);
        chk("reset_code", 64'(err_code), 64'd0);
        chk("reset_state", 64'(dbg_state), 64'(IDLE));
        res = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_txn(vecs[i], -1, dc, nv, fr, b1, ed, fv);
            chk("done_cycle", 64'(dc), 64'(vecs[i].exp_done));
            chk("error_at_done", 64'(ed), 64'(vecs[i].exp_err));
            chk("err_code", 64'(err_code), 64'(vecs[i].exp_code));
            chk("r1_out", 64'(r1_out), 64'(vecs[i].exp_r1));
            chk("valid_count", 64'(nv), 64'(vecs[i].exp_valid));
            chk("crc_out", 64'(crc_out), 64'(vecs[i].exp_crc));
            chk("cmd_frame", 64'(fr), 64'({8'h51, vecs[i].addr, 8'hFF}));
            chk("busy_at_t1", 64'(b1), 64'd1);
            if (vecs[i].exp_valid > 0) chk("first_strobe", 64'(fv), 64'(vecs[i].exp_done - 4112));
        end

        // Reset in the middle of the data phase.
        run_txn(vecs[0], 100, dc, nv, fr, b1, ed, fv);
        chk("abort_count", 64'(nv), 64'd100);
        repeat (3) begin
            @(negedge clk);
            chk("no_done_in_reset", 64'(done), 64'd0);
        end
        res = 1'b0;
        MISO_bit = 1'b1;

        // start with init_done low is ignored.
        init_done = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (k == 0 || k == 19) begin
                chk("no_init_busy", 64'(busy), 64'd0);
                chk("no_init_cs", 64'(sd_cs), 64'd1);
            end
        end
        init_done = 1'b1;

        run_txn(vecs[0], -1, dc, nv, fr, b1, ed, fv);
        chk("fresh_done_cycle", 64'(dc), 64'd4193);
        chk("fresh_error", 64'(ed), 64'd0);
        chk("fresh_valid_count", 64'(nv), 64'd512);
        chk("fresh_crc", 64'(crc_out), 64'hA5C3);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sd_read_block.md
# sd_read_block

SPI-mode single-block reader that sits directly downstream of the SD card initialisation stage. Once `init_done` is asserted it owns the card's `sd_cs`/`MOSI_bit`/`MISO_bit` lines. On each `start` it issues CMD17 for a 32-bit block address, checks the R1 response and searches for the start-data token. It then streams the block out as bytes with a valid strobe, followed by the 16-bit CRC.

## Interface
- `BLOCK_BYTES`, 512: data bytes per block.
- `NCR_MAX`, 64: bit-times allowed for the first R1 bit (a 0 bit) to appear after the command.
- `TOKEN_MAX`, 65535: bit-times allowed for the start-data token after R1.
- `clk` in 1: single clock. One SPI bit per cycle; `clk` is also the card SCLK.
- `res` in 1: asynchronous reset, active-high.
- `init_done` in 1: level from the init stage. While low, `start` is ignored.
- `start` in 1: one-cycle request. Accepted only in IDLE with `init_done` = 1.
- `addr` in 32: block address. Sampled on the cycle `start` is accepted.
- `MISO_bit` in 1: card data out. Sampled on rising `clk`.
- `sd_cs` out 1: card select, active-low.
- `MOSI_bit` out 1: card data in. Updated on rising `clk`.
- `busy` out 1: high from the cycle after acceptance until the cycle `done` pulses.
- `data_out` out 8: received byte, MSB first on the wire.
- `data_valid` out 1: one-cycle strobe qualifying `data_out`.
- `crc_out` out 16: received data CRC. Valid from `done` until the next accept. Not checked.
- `r1_out` out 8: last R1 byte received.
- `done` out 1: one-cycle pulse at the end of the transaction, success or failure.
- `error` out 1: qualifies `done`. Held until the next accept.
- `err_code` out 2: 1 = R1 nonzero, 2 = R1 timeout, 3 = token timeout or data-error token.

## Operation
- Reset values:
  - `sd_cs` = 1, `MOSI_bit` = 1.
  - `busy`, `data_valid`, `done`, `error` = 0.
  - `data_out`, `crc_out` = 0; `r1_out` = 8'hFF; `err_code` = 0.
  - State = IDLE.
- IDLE: on accept, latch the frame {8'h51, addr, 8'hFF} into a 48-bit shift register, then go to PRE.
- PRE: 8 cycles with `sd_cs` = 1 and `MOSI_bit` = 1, then CMD.
- CMD: `sd_cs` = 0. Shift out 48 bits, MSB first, one per cycle, then R1WAIT.
- R1WAIT: `MOSI_bit` = 1.
  - The first sampled 0 starts R1 capture; that bit is R1[7]. Capture 8 bits total.
  - No 0 within `NCR_MAX` samples → ERR, code 2.
  - R1 ≠ 0 → ERR, code 1.
  - R1 = 0 → TOKEN.
- TOKEN: an 8-bit sliding shift register, checked every cycle.
  - 8'hFE → DATA.
  - A pattern 8'b0000_xxxx with any nonzero low nibble, detected only when the window begins immediately after a run of ones → ERR, code 3.
  - `TOKEN_MAX` samples without a token → ERR, code 3.
- DATA: `BLOCK_BYTES` × 8 bits. After every 8th bit, `data_out` is loaded and `data_valid` pulses once. Then CRC.
- CRC: 16 bits into `crc_out`, MSB first, then POST.
- POST: `sd_cs` = 1, `MOSI_bit` = 1 for 8 cycles. Pulse `done`, return to IDLE.
- ERR: same 8-cycle POST sequence, then `done` = 1 and `error` = 1 together.
- `start` while busy is ignored, with no queueing. `start` in the same cycle as `done` is also ignored.
- An `init_done` fall mid-transaction is ignored; the transaction completes.
- Reset mid-transaction: all outputs return to their reset values immediately. No `done` is emitted.
- Counters: 16-bit timeout counter; 13-bit data bit counter, which wraps only via state exit.

## Timing
- Accept cycle T:
  - `busy` = 1 at T+1.
  - PRE covers T+1..T+8.
  - The first CMD bit (0) is on `MOSI_bit` at T+9.
  - The last CMD bit is at T+56.
- The R1 bit is sampled at the earliest at T+57.
- `data_valid` rises on the cycle after the 8th bit of each byte is sampled. Strobes are spaced exactly 8 cycles apart.
- Fastest clean card (R1 at the first sample, token immediately after): `done` at T+57+8+8+4096+16+8.

## Structure
- Shared package holds:
  - state enum: IDLE, PRE, CMD, R1WAIT, TOKEN, DATA, CRC, POST, ERR;
  - CMD17 index 8'h51 and the dummy CRC 8'hFF;
  - token 8'hFE;
  - `err_code` values.
- One sub-module, `spi_byte_rx`: an 8-bit serial-in shift register with a bit counter and a byte-strobe output. Reused for R1, data and CRC.

## Test plan
- Card model returns R1 = 8'h00 after 3 bits, token after 20 bits, bytes 0x00..0xFF repeated, CRC 16'hA5C3 → 512 strobes in order; `crc_out` = 16'hA5C3; `done` = 1, `error` = 0.
- `addr` = 32'h0000_1234 → MOSI frame bits equal 48'h51_0000_1234_FF, starting at T+9.
- MISO held at 1 → after 64 R1 samples, `done` = 1, `error` = 1, `err_code` = 2; `sd_cs` = 1 afterwards.
- R1 = 8'h04 → `err_code` = 1, `r1_out` = 8'h04, no `data_valid`.
- Data-error token 8'h08 → `err_code` = 3. Separately, a token that never arrives → `err_code` = 3 after 65535 samples.
- `res` asserted at byte 100 → `sd_cs` = 1, `busy` = 0 asynchronously. After release, `start` with `init_done` = 0 is ignored; with `init_done` = 1 a fresh clean read completes.
